mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, producing the architectural HI/LO pair. It consumes the two operand words read from the register file (rs, rt) for MULT/MULTU/DIV/DIVU. It holds HI/LO for MFHI/MFLO, and accepts MTHI/MTLO writes. Results leave through `hi`/`lo` toward the write-back mux feeding the register file write port. One operation runs at a time, with a busy/done handshake to the control unit.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  multiplicand or dividend, from the register file read port 1.
- `rt_data`  in  32  multiplier or divisor, from the register file read port 2.
- `hi_we`  in  1  MTHI strobe.
- `lo_we`  in  1  MTLO strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  single-cycle pulse: HI/LO just updated by an operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **States:** IDLE, RUN, FIX. A 5-bit iteration counter drives RUN.
- **IDLE**
  - `start`=1 latches `op` and the operands.
  - For signed ops (MULT, DIV), the absolute values are latched, along with both sign bits.
  - The counter loads 31, then the state moves to RUN.
- **RUN (multiply):** shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- **RUN (divide):** restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- **RUN exit:** at counter = 0, the state moves to FIX.
- **FIX, multiply:** the product is negated if the signs differ (signed ops only). HI = product[63:32], LO = product[31:0].
- **FIX, divide, quotient:** negated if the signs differ. LO = quotient.
- **FIX, divide, remainder:** takes the sign of the dividend. HI = remainder.
- **FIX exit:** `done` pulses and the state returns to IDLE.
- **Divide by zero:** no trap. The raw algorithm result is kept: DIVU gives LO=32'hFFFF_FFFF, HI=rs_data. DIV applies the normal sign fix to those raw values.
- **Signed overflow:** DIV 32'h8000_0000 / 32'hFFFF_FFFF gives LO=32'h8000_0000, HI=0.
- **MTHI/MTLO:** `hi_we`/`lo_we` write `wdata` at the clock edge, in IDLE only. They are ignored in RUN/FIX.
- **`start` with `hi_we`/`lo_we` in the same IDLE cycle:** both take effect. The operation's later FIX overwrites HI/LO.
- **`start` during RUN/FIX:** ignored. No queueing.
- **Internal state:** the operand latches are internal. `rs_data`/`rt_data` may change freely after the start cycle.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- **Mid-operation reset:** reset asserted mid-operation aborts immediately to the reset values.
- **Edge E0:** `start` is accepted. `busy`=1 from E0.
- **Edges E1..E32:** the 32 RUN iterations.
- **Edge E33:** FIX. HI/LO update, `busy`→0, `done`→1 for exactly one cycle.
- **Latency:** 33 cycles from the accepting edge to `done`/results visible.
- **Back-to-back:** a new `start` may be asserted in the cycle where `done`=1. It is accepted at the next edge, giving a throughput of one op per 34 cycles.
- **Register timing:** `hi`/`lo` are registered outputs and change only at E33 or on an accepted MTHI/MTLO edge.

## Configuration
- **`MDU_DIV_EN` defined:** DIV/DIVU are implemented as above.
- **`MDU_DIV_EN` undefined:**
  - The divide datapath is not built.
  - DIV/DIVU still run the full 33-cycle busy/done sequence, but leave HI/LO unchanged.
  - Multiply behaviour and timing are identical.

## Structure
- **Package `mdu_pkg`:**
  - op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`);
  - the state enum (IDLE/RUN/FIX);
  - the `MDU_ITER`=32 constant.
- **Sub-module `mdu_sign_fix`:** combinational. Inputs are the sign bits, the op, and the raw 64-bit result. Output is the signed-corrected HI/LO, used in FIX.

## Test plan
- **Reset:** reset, then MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF → `done` at cycle 33, HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- **Signed multiply:** MULT −6 × 7 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFD6. DIV −7 / 2 → LO=32'hFFFF_FFFD (−3), HI=32'hFFFF_FFFF (−1).
- **Divide corner cases:** DIVU 100 / 0 → HI=100, LO=32'hFFFF_FFFF. DIV 32'h8000_0000 / −1 → LO=32'h8000_0000, HI=0.
- **MTHI/MTLO:** MTHI 32'hA5A5_A5A5 in IDLE → `hi` updates next edge. `hi_we` and a second `start` during RUN are both ignored. Final results match the first op only.
- **Reset mid-op:** assert `rst_n`=0 at RUN iteration 10 → immediate `busy`=0, `hi`=`lo`=0. A fresh MULTU 3 × 5 afterwards → LO=15 after 33 cycles.
- **`MDU_DIV_EN` undefined:** DIVU 10 / 3 → `busy` for 33 cycles, `done` pulses, HI/LO keep their prior values.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - operation encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
//     - FSM state enumeration (IDLE / RUN / FIX)
//     - MDU_ITER : number of RUN iterations (one bit per cycle, 32-bit operands)
//   Configuration macro: MDU_DIV_EN (see mult_div_unit.sv).
// -----------------------------------------------------------------------------
package mdu_pkg;

    // op[1] selects divide, op[0] selects the unsigned variant.
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    localparam int MDU_ITER = 32;

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
//   Combinational sign correction applied in the FIX state. The iterative core
//   always works on magnitudes; this block restores the architectural sign.
//     - MULT : 64-bit product negated when the operand signs differ
//     - DIV  : quotient (LO) negated when the signs differ,
//              remainder (HI) takes the sign of the dividend
//     - MULTU / DIVU : pass-through
//   The divide correction is only built when MDU_DIV_EN is defined.
//
// Ports
//   sign_a  in   1   sign of rs operand (0 for unsigned ops)
//   sign_b  in   1   sign of rt operand (0 for unsigned ops)
//   op      in   2   operation code (mdu_pkg encodings)
//   raw     in  64   unsigned result: {product} or {remainder, quotient}
//   hi      out 32   corrected HI
//   lo      out 32   corrected LO
// -----------------------------------------------------------------------------
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [1:0]  op,
    input  logic [63:0] raw,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] raw_neg;

    assign raw_neg = -raw;

    always_comb begin
        hi = raw[63:32];
        lo = raw[31:0];
        case (op)
            MDU_MULT: begin
                if (sign_a ^ sign_b) begin
                    hi = raw_neg[63:32];
                    lo = raw_neg[31:0];
                end
            end
`ifdef MDU_DIV_EN
            MDU_DIV: begin
                if (sign_a ^ sign_b) begin
                    lo = -raw[31:0];
                end
                if (sign_a) begin
                    hi = -raw[63:32];
                end
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative 32-bit multiply/divide unit producing the MIPS HI/LO pair.
//   MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider; both
//   retire one bit per cycle. An accepted op takes 33 cycles from the start
//   edge to done (32 RUN iterations + 1 FIX cycle). MTHI/MTLO writes are
//   honoured only while idle.
//
//   Handshake: start is sampled only in IDLE; the accepting edge raises busy.
//   busy stays high until the FIX edge, where HI/LO update and done pulses for
//   exactly one cycle. A start held during that done cycle is accepted at the
//   next edge; a start seen while busy is dropped, never queued.
//
//   Configuration macro MDU_DIV_EN:
//     defined   - DIV/DIVU fully implemented.
//     undefined - divide datapath not built; DIV/DIVU still run the full
//                 busy/done sequence but leave HI/LO unchanged.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      operation request (IDLE only)
//   op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  in   WIDTH  multiplicand / dividend
//   rt_data  in   WIDTH  multiplier / divisor
//   hi_we    in   1      MTHI strobe
//   lo_we    in   1      MTLO strobe
//   wdata    in   WIDTH  MTHI/MTLO data
//   busy     out  1      operation in flight
//   done     out  1      one-cycle pulse, HI/LO just written by an operation
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = MDU_IDLE;
    localparam logic [1:0] S_RUN  = MDU_RUN;
    localparam logic [1:0] S_FIX  = MDU_FIX;

    localparam logic [4:0] CNT_LOAD = 5'(MDU_ITER - 1);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        sign_a;
    logic        sign_b;
    // Multiplicand for multiply, divisor for divide (always a magnitude).
    logic [31:0] opnd_b;
    // Multiply: {partial product high, multiplier / product low}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [63:0] acc;

    // ---------------------------------------------------------------------
    // Operand conditioning at the start edge
    // ---------------------------------------------------------------------
    logic        signed_op;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;

    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs_data[31];
    assign rt_neg    = signed_op & rt_data[31];
    // -0x8000_0000 wraps back to 0x8000_0000, which is the correct magnitude
    // when read as unsigned.
    assign rs_abs    = rs_neg ? -rs_data : rs_data;
    assign rt_abs    = rt_neg ? -rt_data : rt_data;

    // ---------------------------------------------------------------------
    // Multiply step: add multiplicand if the current multiplier bit is set,
    // then shift the 65-bit {carry, acc} right by one.
    // ---------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

`ifdef MDU_DIV_EN
    // ---------------------------------------------------------------------
    // Restoring divide step. acc[63:31] is the remainder shifted left with
    // the next dividend bit appended (33-bit partial remainder). A negative
    // trial keeps the shifted value and shifts a 0 into the quotient.
    // With a zero divisor the trial never goes negative, so the raw result
    // is quotient = all ones, remainder = dividend.
    // ---------------------------------------------------------------------
    logic [32:0] div_trial;
    logic [63:0] div_next;

    assign div_trial = acc[63:31] - {1'b0, opnd_b};
    assign div_next  = div_trial[32] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};
`endif

    // ---------------------------------------------------------------------
    // Sign restoration used in FIX
    // ---------------------------------------------------------------------
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    mdu_sign_fix u_sign_fix (
        .sign_a (sign_a),
        .sign_b (sign_b),
        .op     (op_q),
        .raw    (acc),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );

    // ---------------------------------------------------------------------
    // Control FSM and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            op_q   <= MDU_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd_b <= 32'd0;
            acc    <= 64'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // MTHI/MTLO and start may coincide; the later FIX of the
                    // started op overwrites whatever was written here.
                    if (hi_we) begin
                        hi <= wdata;
                    end
                    if (lo_we) begin
                        lo <= wdata;
                    end
                    if (start) begin
                        op_q   <= op;
                        sign_a <= rs_neg;
                        sign_b <= rt_neg;
                        if (op[1]) begin
                            opnd_b <= rt_abs;
                            acc    <= {32'd0, rs_abs};
                        end else begin
                            opnd_b <= rs_abs;
                            acc    <= {32'd0, rt_abs};
                        end
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (op_q[1]) begin
`ifdef MDU_DIV_EN
                        acc <= div_next;
`endif
                    end else begin
                        acc <= mul_next;
                    end
                    if (cnt == 5'd0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end

                S_FIX: begin
`ifdef MDU_DIV_EN
                    hi <= fix_hi;
                    lo <= fix_lo;
`else
                    if (!op_q[1]) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
`endif
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed self-checking bench for mult_div_unit. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
//   Divide expectations depend on whether MDU_DIV_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Driver tasks (called at a falling edge, return at a falling edge)
    // ---------------------------------------------------------------------
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Counts falling edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = h;
        @(negedge clk);
        hi_we = 1'b0;
        wdata = l;
        lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        rst_n = 1'b1;
        @(negedge clk);

        start_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b expected 1", busy); end
        wait_done(n);
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h expected fffffffe", hi); end
        n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h expected 00000001", lo); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_multiply();
        int n;
        start_op(MDU_MULT, 32'hFFFF_FFFA, 32'd7);
        wait_done(n);
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg6x7_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFD6) begin n_fail++; $display("FAIL mult_neg6x7_lo: got %h expected ffffffd6", lo); end
        @(negedge clk);
        start_op(MDU_MULT, 32'h8000_0000, 32'd2);
        wait_done(n);
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_min_x2_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_x2_lo: got %h expected 00000000", lo); end
        @(negedge clk);
        start_op(MDU_MULTU, 32'h1234_5678, 32'h0000_0010);
        wait_done(n);
        n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_shift_hi: got %h expected 00000001", hi); end
        n_checks++; if (lo !== 32'h2345_6780) begin n_fail++; $display("FAIL multu_shift_lo: got %h expected 23456780", lo); end
        @(negedge clk);
        start_op(MDU_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        wait_done(n);
        n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_negneg_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h0000_000F) begin n_fail++; $display("FAIL mult_negneg_lo: got %h expected 0000000f", lo); end
        @(negedge clk);
    endtask

`ifdef MDU_DIV_EN
    task automatic test_divide();
        int n;
        start_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", n); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg7by2_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg7by2_hi: got %h expected ffffffff", hi); end
        @(negedge clk);
        start_op(MDU_DIVU, 32'd100, 32'd0);
        wait_done(n);
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0_lo: got %h expected ffffffff", lo); end
        n_checks++; if (hi !== 32'd100) begin n_fail++; $display("FAIL divu_by0_hi: got %h expected 00000064", hi); end
        @(negedge clk);
        start_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
        @(negedge clk);
        start_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7byneg2_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_7byneg2_hi: got %h expected 00000001", hi); end
        @(negedge clk);
        start_op(MDU_DIVU, 32'hF000_0000, 32'h0000_0003);
        wait_done(n);
        n_checks++; if (lo !== 32'h5000_0000) begin n_fail++; $display("FAIL divu_large_lo: got %h expected 50000000", lo); end
        n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL divu_large_hi: got %h expected 00000000", hi); end
        @(negedge clk);
    endtask
`else
    task automatic test_div_disabled();
        int n;
        write_hilo(32'h1111_1111, 32'h2222_2222);
        start_op(MDU_DIVU, 32'd10, 32'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL divdis_busy: got %b expected 1", busy); end
        wait_done(n);
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL divdis_latency: got %0d expected 33", n); end
        n_checks++; if (hi !== 32'h1111_1111) begin n_fail++; $display("FAIL divdis_hi: got %h expected 11111111", hi); end
        n_checks++; if (lo !== 32'h2222_2222) begin n_fail++; $display("FAIL divdis_lo: got %h expected 22222222", lo); end
        @(negedge clk);
        start_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL divdis_signed_done: got %b expected 1", done); end
        n_checks++; if (hi !== 32'h1111_1111) begin n_fail++; $display("FAIL divdis_signed_hi: got %h expected 11111111", hi); end
        n_checks++; if (lo !== 32'h2222_2222) begin n_fail++; $display("FAIL divdis_signed_lo: got %h expected 22222222", lo); end
        @(negedge clk);
    endtask
`endif

    task automatic test_mthi_mtlo();
        int n;
        logic [31:0] lo_before;
        lo_before = lo;
        hi_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi_idle: got %h expected a5a5a5a5", hi); end
        n_checks++; if (lo !== lo_before) begin n_fail++; $display("FAIL mthi_lo_kept: got %h expected %h", lo, lo_before); end
        lo_we = 1'b1;
        wdata = 32'h5A5A_0000;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h5A5A_0000) begin n_fail++; $display("FAIL mtlo_idle: got %h expected 5a5a0000", lo); end

        // Writes and a second start during RUN must be ignored.
        start_op(MDU_MULTU, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        wdata   = 32'h1234_5678;
        start   = 1'b1;
        op      = MDU_MULTU;
        rs_data = 32'd7;
        rt_data = 32'd7;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b0;
        n_checks++; if (hi !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mthi_run_ignored: got %h expected a5a5a5a5", hi); end
        n_checks++; if (lo !== 32'h5A5A_0000) begin n_fail++; $display("FAIL mtlo_run_ignored: got %h expected 5a5a0000", lo); end
        wait_done(n);
        n_checks++; if (n + 6 != 33) begin n_fail++; $display("FAIL run_ignore_latency: got %0d expected 33", n + 6); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL run_ignore_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'd15) begin n_fail++; $display("FAIL run_ignore_lo: got %h expected 0000000f", lo); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_queued_op: got busy %b expected 0", busy); end

        // start and MTHI in the same idle cycle: both take effect.
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        start_op(MDU_MULTU, 32'd2, 32'd3);
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL same_cycle_mthi: got %h expected deadbeef", hi); end
        wait_done(n);
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL same_cycle_fix_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL same_cycle_fix_lo: got %h expected 00000006", lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int n;
        write_hilo(32'hCAFE_0001, 32'hCAFE_0002);
        start_op(MDU_MULTU, 32'hFFFF_0000, 32'h0000_FFFF);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_reset_busy: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midop_reset_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL midop_reset_lo: got %h expected 00000000", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_stays_idle: got %b expected 0", busy); end
        start_op(MDU_MULTU, 32'd3, 32'd5);
        wait_done(n);
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 33", n); end
        n_checks++; if (lo !== 32'd15) begin n_fail++; $display("FAIL post_reset_lo: got %h expected 0000000f", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL post_reset_hi: got %h expected 00000000", hi); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(MDU_MULTU, 32'd1000, 32'd1000);
        wait_done(n);
        n_checks++; if (lo !== 32'd1_000_000) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 000f4240", lo); end
        // start asserted in the done cycle, accepted at the following edge
        start_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        wait_done(n);
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", n); end
        n_checks++; if (lo !== 32'd1) begin n_fail++; $display("FAIL b2b_second_lo: got %h expected 00000001", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL b2b_second_hi: got %h expected 00000000", hi); end
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = MDU_MULT;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = 32'd0;
        @(negedge clk);

        test_reset();
        test_multiply();
`ifdef MDU_DIV_EN
        test_divide();
`else
        test_div_disabled();
`endif
        test_mthi_mtlo();
        test_reset_midop();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
